button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250000, meaning the consecutive stable cycles needed to accept a level change (minimum 2).
REQ-002 SHALL have parameter REPEAT_DELAY, default 12500000, meaning the held cycles from the press pulse to the first repeat pulse (minimum 2).
REQ-003 SHALL have parameter REPEAT_PERIOD, default 2500000, meaning the cycles between subsequent repeat pulses (minimum 2).
REQ-004 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port btn_raw, input, 4 bits: raw asynchronous active-high buttons; bit 0=left, 1=right, 2=up, 3=down.
REQ-007 SHALL have port btn_level, output, 4 bits: debounced level per button.
REQ-008 SHALL have port btn_press, output, 4 bits: one-cycle pulse per accepted press or repeat event.
REQ-009 SHALL have port btn_release, output, 4 bits: one-cycle pulse per accepted release.

Function
REQ-010 SHALL pass each btn_raw bit through a 2-flop synchronizer before any other use.
REQ-011 SHALL keep a per-button debounce counter that increments while the synchronized bit differs from btn_level, clears to 0 when they match, and saturates instead of wrapping.
REQ-012 SHALL toggle btn_level and clear the counter on the edge where the counter would reach DEBOUNCE_CYCLES.
REQ-013 SHALL make btn_level change exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples a steady new raw value.
REQ-014 SHALL drop any raw glitch shorter than DEBOUNCE_CYCLES cycles without any output change.
REQ-015 SHALL assert btn_press for exactly one cycle, registered, in the same cycle btn_level first reads 1.
REQ-016 SHALL assert btn_release for exactly one cycle in the same cycle btn_level first reads 0.
REQ-017 SHALL treat the four channels independently, so simultaneous events on several buttons yield simultaneous pulses.
REQ-018 SHALL never assert btn_press and btn_release together on the same bit.
REQ-019 SHALL size every counter as $clog2(max count + 1) bits, unsigned.

Reset
REQ-020 SHALL, while rst=1, asynchronously clear all synchronizer flops, counters, state registers, btn_level, btn_press and btn_release to 0.
REQ-021 SHALL, for a button held through reset deassertion, treat the hold as a new press requiring the full debounce before btn_press.
REQ-022 SHALL, on reset mid-debounce or mid-repeat, discard all progress with no pulse emitted during or at release of reset.

Configuration
REQ-023 SHALL, with macro BTN_AUTOREPEAT_EN defined, run a per-button FSM IDLE -> HELD -> REPEAT:
- IDLE -> HELD on btn_level rise.
- HELD -> REPEAT after REPEAT_DELAY cycles, with one btn_press pulse.
- In REPEAT, one btn_press pulse every REPEAT_PERIOD cycles.
- Any state -> IDLE on btn_level fall; the repeat counter clears.
REQ-024 SHALL, without BTN_AUTOREPEAT_EN, exclude the FSM and repeat counters from compilation, giving exactly one btn_press per accepted press however long the button is held.

Structure
REQ-025 SHALL place in shared package btn_pkg:
- button index constants BTN_LEFT=0, BTN_RIGHT=1, BTN_UP=2, BTN_DOWN=3.
- NUM_BTNS=4.
- the repeat FSM state enum.
REQ-026 SHALL implement one channel (synchronizer, debounce, optional repeat) as sub-module btn_channel, instantiated NUM_BTNS times by button_conditioner.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-027 SHALL show: btn_raw[0] steady 1 from edge 0 -> btn_level[0]=1 and btn_press[0]=1 after edge 6, btn_press[0]=0 after edge 7.
REQ-028 SHALL show: btn_raw[2] high for 3 cycles then low -> btn_level, btn_press and btn_release all stay 0.
REQ-029 SHALL show: btn_raw=4'b1001 applied in one cycle -> btn_press=4'b1001 in a single cycle; release of both -> btn_release=4'b1001 in a single cycle.
REQ-030 SHALL show: with BTN_AUTOREPEAT_EN, btn_raw[1] held -> btn_press[1] pulses at edges 6, 16, 19 and 22, and no pulse after btn_level falls.
REQ-031 SHALL show: rst asserted at edge 4 of a press and released at edge 8 with raw still 1 -> outputs 0 during reset; btn_press asserts 6 edges after reset release, with no spurious btn_release.
REQ-032 SHALL show: without BTN_AUTOREPEAT_EN, a 50-cycle hold -> exactly one btn_press pulse and one btn_release pulse.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared constants and types for the four-button conditioner.
// Button indices, channel count and the auto-repeat state encoding.
package btn_pkg;

   localparam int BTN_LEFT  = 0;
   localparam int BTN_RIGHT = 1;
   localparam int BTN_UP    = 2;
   localparam int BTN_DOWN  = 3;
   localparam int NUM_BTNS  = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HELD   = 2'd1,
      ST_REPEAT = 2'd2
   } rep_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchronizer, saturating debounce, edge pulses.
// Define BTN_AUTOREPEAT_EN to add the IDLE/HELD/REPEAT auto-repeat FSM.
module btn_channel
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int REPEAT_DELAY    = 12500000,
   parameter int REPEAT_PERIOD   = 2500000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic press,
   output logic rel
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES);

   logic [1:0]    sync_reg;
   logic [DW-1:0] cnt_reg;
   logic          level_reg;
   logic          press_reg;
   logic          rel_reg;

   logic differ;
   logic toggle;
   logic rise;
   logic fall;

   // The counter saturates at DB_MAX, so the toggle happens one edge later,
   // giving DEBOUNCE_CYCLES+2 edges from the first raw sample to the new level.
   assign differ = sync_reg[1] ^ level_reg;
   assign toggle = differ && (cnt_reg == DB_MAX);
   assign rise   = toggle && !level_reg;
   assign fall   = toggle && level_reg;

`ifdef BTN_AUTOREPEAT_EN
   localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
   localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

   rep_state_t    state_reg;
   logic [RW-1:0] rcnt_reg;
   logic          fire;

   assign fire = !fall &&
                 (((state_reg == ST_HELD)   && (rcnt_reg == DLY_LAST)) ||
                  ((state_reg == ST_REPEAT) && (rcnt_reg == PER_LAST)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         rcnt_reg  <= '0;
      end else if (fall) begin
         state_reg <= ST_IDLE;
         rcnt_reg  <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               rcnt_reg <= '0;
               if (rise) state_reg <= ST_HELD;
            end
            ST_HELD: begin
               if (rcnt_reg == DLY_LAST) begin
                  state_reg <= ST_REPEAT;
                  rcnt_reg  <= '0;
               end else begin
                  rcnt_reg <= rcnt_reg + RW'(1);
               end
            end
            ST_REPEAT: begin
               if (rcnt_reg == PER_LAST) rcnt_reg <= '0;
               else                      rcnt_reg <= rcnt_reg + RW'(1);
            end
            default: begin
               state_reg <= ST_IDLE;
               rcnt_reg  <= '0;
            end
         endcase
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_reg  <= '0;
         cnt_reg   <= '0;
         level_reg <= 1'b0;
         press_reg <= 1'b0;
         rel_reg   <= 1'b0;
      end else begin
         sync_reg <= {sync_reg[0], raw};
         if (!differ) begin
            cnt_reg <= '0;
         end else if (toggle) begin
            cnt_reg   <= '0;
            level_reg <= ~level_reg;
         end else begin
            cnt_reg <= cnt_reg + DW'(1);
         end
`ifdef BTN_AUTOREPEAT_EN
         press_reg <= rise || fire;
`else
         press_reg <= rise;
`endif
         rel_reg <= fall;
      end
   end

   assign level = level_reg;
   assign press = press_reg;
   assign rel   = rel_reg;

endmodule

// File: rtl/button_conditioner.sv
// Four independent button channels (left, right, up, down) with debounce and
// press/release pulses; auto-repeat is enabled by defining BTN_AUTOREPEAT_EN.
module button_conditioner
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int REPEAT_DELAY    = 12500000,
   parameter int REPEAT_PERIOD   = 2500000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] btn_raw,
   output logic [3:0] btn_level,
   output logic [3:0] btn_press,
   output logic [3:0] btn_release
);

   generate
      for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_chan
         btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
         ) u_chan (
            .clk   (clk),
            .rst   (rst),
            .raw   (btn_raw[gi]),
            .level (btn_level[gi]),
            .press (btn_press[gi]),
            .rel   (btn_release[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner (DEBOUNCE=4, DELAY=10, PERIOD=3).
// Expected pulses are queued with their edge index and matched as they appear.
module tb_button_conditioner;
   import btn_pkg::*;

   localparam int DB = 4;
   localparam int RD = 10;
   localparam int RP = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] btn_raw;
   logic [3:0] btn_level;
   logic [3:0] btn_press;
   logic [3:0] btn_release;

   always #5 clk = ~clk;

   button_conditioner #(
      .DEBOUNCE_CYCLES (DB),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_raw     (btn_raw),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release)
   );

   typedef struct {
      int         edge_no;
      logic [3:0] press;
      logic [3:0] rel;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   edge_idx = 0;   // index of the next rising edge

   function automatic void expect_ev(input int e, input logic [3:0] p, input logic [3:0] r);
      exp_t x;
      x.edge_no = e;
      x.press   = p;
      x.rel     = r;
      sb.push_back(x);
   endfunction

   // Advance n edges; after each, match any pulse against the scoreboard head.
   task automatic step(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         edge_idx++;
         @(negedge clk);
         if ((btn_press | btn_release) != 4'b0000) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL unexpected_pulse edge=%0d press=%b release=%b required none",
                        edge_idx - 1, btn_press, btn_release);
            end else begin
               e = sb.pop_front();
               if (e.edge_no != edge_idx - 1 || btn_press !== e.press || btn_release !== e.rel) begin
                  failures++;
                  $display("FAIL pulse edge=%0d press=%b release=%b required edge=%0d press=%b release=%b",
                           edge_idx - 1, btn_press, btn_release, e.edge_no, e.press, e.rel);
               end
            end
         end else if (sb.size() != 0 && sb[0].edge_no <= edge_idx - 1) begin
            checks++;
            failures++;
            e = sb.pop_front();
            $display("FAIL missing_pulse edge=%0d press=%b release=%b required press=%b release=%b",
                     e.edge_no, btn_press, btn_release, e.press, e.rel);
         end
      end
   endtask

   task automatic test_reset();
      rst     = 1'b1;
      btn_raw = 4'b0000;
      step(3);
      checks++;
      if ({btn_level, btn_press, btn_release} !== 12'h000) begin
         failures++;
         $display("FAIL reset_outputs got=%h required=000", {btn_level, btn_press, btn_release});
      end
      rst = 1'b0;
      step(2);
   endtask

   task automatic test_single_press();
      int c;
      c = edge_idx;
      btn_raw = 4'b0001;
      expect_ev(c + DB + 2, 4'b0001, 4'b0000);
      step(DB + 2);
      checks++;
      if (btn_level !== 4'b0000) begin
         failures++;
         $display("FAIL single_level_early got=%b required=0000", btn_level);
      end
      step(1);
      checks++;
      if (btn_level !== 4'b0001) begin
         failures++;
         $display("FAIL single_level got=%b required=0001", btn_level);
      end
      step(1);
      checks++;
      if (btn_press !== 4'b0000) begin
         failures++;
         $display("FAIL single_press_width got=%b required=0000", btn_press);
      end
      c = edge_idx;
      btn_raw = 4'b0000;
      expect_ev(c + DB + 2, 4'b0000, 4'b0001);
      step(10);
      checks++;
      if (btn_level !== 4'b0000 || sb.size() != 0) begin
         failures++;
         $display("FAIL single_release level=%b pending=%0d required level=0000 pending=0",
                  btn_level, sb.size());
      end
   endtask

   task automatic test_glitch();
      btn_raw = 4'b0100;
      step(3);
      btn_raw = 4'b0000;
      step(20);
      checks++;
      if (btn_level !== 4'b0000) begin
         failures++;
         $display("FAIL glitch_level got=%b required=0000", btn_level);
      end
   endtask

   task automatic test_simultaneous();
      int c;
      c = edge_idx;
      btn_raw = 4'b1001;
      expect_ev(c + DB + 2, 4'b1001, 4'b0000);
      step(8);
      checks++;
      if (btn_level !== 4'b1001) begin
         failures++;
         $display("FAIL simul_level got=%b required=1001", btn_level);
      end
      c = edge_idx;
      btn_raw = 4'b0000;
      expect_ev(c + DB + 2, 4'b0000, 4'b1001);
      step(10);
      checks++;
      if (btn_level !== 4'b0000 || sb.size() != 0) begin
         failures++;
         $display("FAIL simul_release level=%b pending=%0d required level=0000 pending=0",
                  btn_level, sb.size());
      end
   endtask

`ifdef BTN_AUTOREPEAT_EN
   task automatic test_autorepeat();
      int c;
      int fall_edge;
      int e;
      c = edge_idx;
      fall_edge = c + 24 + DB + 2;
      btn_raw = 4'b0010;
      expect_ev(c + DB + 2, 4'b0010, 4'b0000);
      e = c + DB + 2 + RD;
      while (e < fall_edge) begin
         expect_ev(e, 4'b0010, 4'b0000);
         e += RP;
      end
      expect_ev(fall_edge, 4'b0000, 4'b0010);
      step(24);
      btn_raw = 4'b0000;
      step(20);
      checks++;
      if (btn_level !== 4'b0000 || sb.size() != 0) begin
         failures++;
         $display("FAIL repeat_end level=%b pending=%0d required level=0000 pending=0",
                  btn_level, sb.size());
      end
   endtask
`else
   task automatic test_long_hold();
      int c;
      c = edge_idx;
      btn_raw = 4'b0001;
      expect_ev(c + DB + 2, 4'b0001, 4'b0000);
      expect_ev(c + 50 + DB + 2, 4'b0000, 4'b0001);
      step(50);
      checks++;
      if (btn_level !== 4'b0001) begin
         failures++;
         $display("FAIL hold_level got=%b required=0001", btn_level);
      end
      btn_raw = 4'b0000;
      step(15);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL hold_pending got=%0d required=0", sb.size());
      end
   endtask
`endif

   task automatic test_reset_mid();
      int c;
      c = edge_idx;
      btn_raw = 4'b0001;
      step(4);
      rst = 1'b1;
      #1;
      checks++;
      if ({btn_level, btn_press, btn_release} !== 12'h000) begin
         failures++;
         $display("FAIL rstmid_async got=%h required=000", {btn_level, btn_press, btn_release});
      end
      step(4);
      checks++;
      if ({btn_level, btn_press, btn_release} !== 12'h000) begin
         failures++;
         $display("FAIL rstmid_hold got=%h required=000", {btn_level, btn_press, btn_release});
      end
      rst = 1'b0;
      expect_ev(c + 8 + DB + 2, 4'b0001, 4'b0000);
      step(7);
      checks++;
      if (btn_level !== 4'b0001) begin
         failures++;
         $display("FAIL rstmid_level got=%b required=0001", btn_level);
      end
      c = edge_idx;
      btn_raw = 4'b0000;
      expect_ev(c + DB + 2, 4'b0000, 4'b0001);
      step(10);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL rstmid_pending got=%0d required=0", sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_glitch();
      test_simultaneous();
`ifdef BTN_AUTOREPEAT_EN
      test_autorepeat();
`else
      test_long_hold();
`endif
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
